// File: rtl/firstn_pkg.sv
// Shared helpers and default sizing for the first-N cluster sequencer.
package firstn_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_NUM_VPFS     = 1536;
  localparam int unsigned DEF_NUM_CLUSTERS = 8;
  localparam int unsigned DEF_CNT_W        = 3;
  localparam int unsigned DEF_ADR_W        = clog2(DEF_NUM_VPFS);

  localparam logic [DEF_ADR_W-1:0] INVALID_ADR = '1;

endpackage

// File: rtl/priority_find_first.sv
// Combinational lowest-set-bit encoder, split into 64-bit groups so the
// group-any OR tree and the two small priority chains run in parallel.
module priority_find_first
  import firstn_pkg::*;
#(
  parameter int unsigned W  = DEF_NUM_VPFS,
  parameter int unsigned AW = clog2(DEF_NUM_VPFS)
) (
  input  logic [W-1:0]  bits,
  output logic          found,
  output logic [AW-1:0] adr
);

  localparam int unsigned GW = 64;
  localparam int unsigned NG = (W + GW - 1) / GW;

  logic [NG*GW-1:0] padded;
  logic [NG-1:0]    group_any;
  logic [GW-1:0]    grp;
  int               gsel;
  int               bsel;

  always_comb begin
    padded = '0;
    padded[W-1:0] = bits;
    for (int g = 0; g < NG; g++) begin
      group_any[g] = |padded[g*GW +: GW];
    end
    // Descending scan so the lowest index wins.
    gsel = 0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (group_any[g]) gsel = g;
    end
    grp  = padded[gsel*GW +: GW];
    bsel = 0;
    for (int b = GW - 1; b >= 0; b--) begin
      if (grp[b]) bsel = b;
    end
    found = |group_any;
    adr   = found ? AW'(gsel * GW + bsel) : '1;
  end

endmodule

// File: rtl/firstn_cluster_sequencer.sv
// Time-multiplexed first-N cluster finder: one find-and-clear per clock4x cycle.
// Optional overflow detection is built only when FIRSTN_OVERFLOW_EN is defined.
module firstn_cluster_sequencer
  import firstn_pkg::*;
#(
  parameter int unsigned NUM_VPFS     = DEF_NUM_VPFS,
  parameter int unsigned NUM_CLUSTERS = DEF_NUM_CLUSTERS,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  localparam int unsigned ADR_W       = clog2(NUM_VPFS)
) (
  input  logic                            clock4x,
  input  logic                            global_reset_n,
  input  logic [3:0]                      delay,
  input  logic [NUM_VPFS-1:0]             vpfs,
  input  logic [NUM_VPFS*CNT_W-1:0]       cnts,
  output logic [NUM_CLUSTERS*ADR_W-1:0]   adr_o,
  output logic [NUM_CLUSTERS*CNT_W-1:0]   cnt_o,
  output logic [NUM_CLUSTERS-1:0]         valid_o,
  output logic                            overflow_o,
  output logic                            frame_strobe_o
);

  localparam int unsigned          PhW       = clog2(NUM_CLUSTERS);
  localparam logic [PhW-1:0]       LastPhase = PhW'(NUM_CLUSTERS - 1);
  localparam logic [ADR_W-1:0]     InvalidAdr = '1;

  logic [PhW-1:0]                phase_q;
  logic [NUM_VPFS-1:0]           vpfs_q, work_q, work_clr;
  logic [NUM_VPFS*CNT_W-1:0]     cnts_q, cnts_work_q;
  logic [NUM_CLUSTERS*ADR_W-1:0] slot_adr_q;
  logic [NUM_CLUSTERS*CNT_W-1:0] slot_cnt_q;
  logic [NUM_CLUSTERS-1:0]       slot_vld_q;
  logic                          found;
  logic [ADR_W-1:0]              enc_adr;
  logic [CNT_W-1:0]              enc_cnt;

  logic unused_delay;
  assign unused_delay = ^delay;

  priority_find_first #(
    .W  (NUM_VPFS),
    .AW (ADR_W)
  ) u_find (
    .bits  (work_q),
    .found (found),
    .adr   (enc_adr)
  );

  always_comb begin
    work_clr = work_q;
    enc_cnt  = '0;
    if (found) begin
      work_clr[enc_adr] = 1'b0;
      enc_cnt = cnts_work_q[int'(enc_adr)*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      phase_q        <= delay[PhW-1:0];
      vpfs_q         <= '0;
      cnts_q         <= '0;
      work_q         <= '0;
      cnts_work_q    <= '0;
      slot_adr_q     <= {NUM_CLUSTERS{InvalidAdr}};
      slot_cnt_q     <= '0;
      slot_vld_q     <= '0;
      adr_o          <= {NUM_CLUSTERS{InvalidAdr}};
      cnt_o          <= '0;
      valid_o        <= '0;
      frame_strobe_o <= 1'b0;
    end else begin
      vpfs_q  <= vpfs;
      cnts_q  <= cnts;
      phase_q <= (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
      // The last extraction cycle doubles as the frame's only sample point.
      if (phase_q == LastPhase) begin
        work_q      <= vpfs_q;
        cnts_work_q <= cnts_q;
      end else begin
        work_q <= work_clr;
      end
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        if (phase_q == PhW'(k)) begin
          slot_adr_q[k*ADR_W +: ADR_W] <= found ? enc_adr : InvalidAdr;
          slot_cnt_q[k*CNT_W +: CNT_W] <= enc_cnt;
          slot_vld_q[k]                <= found;
        end
      end
      frame_strobe_o <= (phase_q == '0);
      if (phase_q == '0) begin
        adr_o   <= slot_adr_q;
        cnt_o   <= slot_cnt_q;
        valid_o <= slot_vld_q;
      end
    end
  end

`ifdef FIRSTN_OVERFLOW_EN
  logic ovf_slot_q, overflow_q;

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      ovf_slot_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (phase_q == LastPhase) ovf_slot_q <= |work_clr;
      if (phase_q == '0)        overflow_q <= ovf_slot_q;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_firstn_cluster_sequencer.sv
// Scoreboard bench: expected banks are queued at each sample cycle and popped
// by an independent monitor on every frame strobe.
module tb_firstn_cluster_sequencer;

  localparam int NV = 1536;
  localparam int NC = 8;
  localparam int CW = 3;
  localparam int AW = 11;
  localparam int NF = 9;

  logic              clock4x = 1'b0;
  logic              global_reset_n = 1'b0;
  logic [3:0]        delay = 4'd0;
  logic [NV-1:0]     vpfs = '0;
  logic [NV*CW-1:0]  cnts = '0;
  logic [NC*AW-1:0]  adr_o;
  logic [NC*CW-1:0]  cnt_o;
  logic [NC-1:0]     valid_o;
  logic              overflow_o;
  logic              frame_strobe_o;

  firstn_cluster_sequencer #(
    .NUM_VPFS     (NV),
    .NUM_CLUSTERS (NC),
    .CNT_W        (CW)
  ) dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .delay          (delay),
    .vpfs           (vpfs),
    .cnts           (cnts),
    .adr_o          (adr_o),
    .cnt_o          (cnt_o),
    .valid_o        (valid_o),
    .overflow_o     (overflow_o),
    .frame_strobe_o (frame_strobe_o)
  );

  always #5 clock4x = ~clock4x;

  typedef struct packed {
    logic [NC*AW-1:0] adr;
    logic [NC*CW-1:0] cnt;
    logic [NC-1:0]    valid;
    logic             ovf;
  } bank_t;

  // Frame table: cluster pads in ascending order with their counts.
  int n_tab [NF] = '{0, 1, 10, 8, 2, 3, 3, 1, 1};
  int pad_tab [NF][10] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 100, 200, 300, 400, 500, 600, 700, 800, 900},
    '{3, 63, 64, 127, 128, 1023, 1024, 1535, 0, 0},
    '{2, 1534, 0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0},
    '{40, 41, 1000, 0, 0, 0, 0, 0, 0, 0},
    '{1535, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };
  int cnt_tab [NF][10] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 2, 3, 4, 5, 6, 7, 0, 2, 5},
    '{7, 1, 2, 3, 4, 5, 6, 7, 0, 0},
    '{6, 5, 0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0},
    '{7, 7, 1, 0, 0, 0, 0, 0, 0, 0},
    '{4, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };

  bank_t exp_q[$];
  bank_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    tb_ph    = 0;
  bit    done     = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic bank_t exp_bank(input int f);
    bank_t b;
    b.adr   = '1;
    b.cnt   = '0;
    b.valid = '0;
    b.ovf   = 1'b0;
    for (int k = 0; k < n_tab[f] && k < NC; k++) begin
      b.adr[k*AW +: AW] = AW'(pad_tab[f][k]);
      b.cnt[k*CW +: CW] = CW'(cnt_tab[f][k]);
      b.valid[k]        = 1'b1;
    end
`ifdef FIRSTN_OVERFLOW_EN
    b.ovf = (n_tab[f] > NC);
`endif
    return b;
  endfunction

  task automatic drive_noise();
    for (int w = 0; w < NV / 32; w++) vpfs[w*32 +: 32] = $urandom();
    for (int w = 0; w < NV * CW / 32; w++) cnts[w*32 +: 32] = $urandom();
  endtask

  task automatic load_frame(input int f);
    drive_noise();
    vpfs = '0;
    for (int i = 0; i < n_tab[f]; i++) begin
      vpfs[pad_tab[f][i]]             = 1'b1;
      cnts[pad_tab[f][i]*CW +: CW]    = CW'(cnt_tab[f][i]);
    end
    exp_q.push_back(exp_bank(f));
  endtask

  task automatic step();
    @(posedge clock4x);
    #1;
    tb_ph = (tb_ph + 1) % NC;
  endtask

  // Noise everywhere except the sample cycle, which carries the next table frame.
  task automatic run_frames(input int first, input int last);
    int f = first;
    while (f <= last) begin
      if (tb_ph == NC - 2) begin
        load_frame(f);
        f++;
      end else begin
        drive_noise();
      end
      step();
    end
  endtask

  task automatic check_reset_bank(input string tag);
    bank_t inv = exp_bank(0);
    check({tag, "_adr"},    adr_o,          inv.adr);
    check({tag, "_cnt"},    cnt_o,          inv.cnt);
    check({tag, "_valid"},  valid_o,        inv.valid);
    check({tag, "_ovf"},    overflow_o,     1'b0);
    check({tag, "_strobe"}, frame_strobe_o, 1'b0);
  endtask

  always @(negedge clock4x) begin
    if (global_reset_n && !done) begin
      check("strobe_phase", frame_strobe_o, tb_ph == 1);
      if (frame_strobe_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bank_underflow: strobe seen, required no strobe");
        end else begin
          mon_e = exp_q.pop_front();
          check("bank_adr",   adr_o,      mon_e.adr);
          check("bank_cnt",   cnt_o,      mon_e.cnt);
          check("bank_valid", valid_o,    mon_e.valid);
          check("bank_ovf",   overflow_o, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    global_reset_n = 1'b0;
    delay = 4'd0;
    repeat (3) @(posedge clock4x);
    #1;
    check_reset_bank("por");
    global_reset_n = 1'b1;
    tb_ph = 0;
    // Strobes in cycles 1 and 9 precede the first sampled frame.
    exp_q.push_back(exp_bank(0));
    exp_q.push_back(exp_bank(0));

    run_frames(1, 4);
    run_frames(5, 6);
    while (tb_ph != 4) begin
      drive_noise();
      step();
    end

    // Reset in phase 4 while frame 6 is mid-extraction and frame 5 is on the bank.
    global_reset_n = 1'b0;
    delay = 4'd3;
    drive_noise();
    step();
    check_reset_bank("mid");
    global_reset_n = 1'b1;
    tb_ph = 3;
    exp_q.delete();
    exp_q.push_back(exp_bank(0));

    run_frames(7, 8);
    for (int i = 0; i < 3 * NC; i++) begin
      if (tb_ph == NC - 2) load_frame(0);
      else drive_noise();
      step();
    end
    check("queue_depth", exp_q.size() <= 2, 1'b1);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
